// File: rtl/strobe_timer_pkg.sv
//==============================================================================
// Module : strobe_timer_pkg -- shared mode/state encodings for the strobe timers
// Rev    : 1.0
//==============================================================================
`default_nettype none

package strobe_timer_pkg;

  localparam logic [1:0] MODE_OFF      = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Reserved encoding 2'b11 behaves like off.
  function automatic logic mode_runs(input logic [1:0] mode);
    return (mode == MODE_PERIODIC) || (mode == MODE_ONESHOT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/strobe_timer_channel.sv
//==============================================================================
// Module : strobe_timer_channel -- one tick counter with shadowed period/mode
// Rev    : 1.0
//==============================================================================
`default_nettype none

module strobe_timer_channel
  import strobe_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [1:0]       cfg_mode,
  output logic             strobe,
  output logic             busy,
  output logic             pending_next
);

  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

  state_t           r_state, w_state_d;
  logic [WIDTH-1:0] r_count, w_count_d;
  logic [WIDTH-1:0] r_period, w_period_d;
  logic [WIDTH-1:0] r_sh_period, w_sh_period_d;
  logic [1:0]       r_mode, w_mode_d;
  logic [1:0]       r_sh_mode, w_sh_mode_d;
  logic             r_pending, w_pending_d;
  logic             r_strobe, w_strobe_d;

  logic             w_wrap;
  logic [WIDTH-1:0] w_eff_period;
  logic [1:0]       w_eff_mode;
  logic             w_eff_runs;

  assign w_wrap       = (r_state == ST_RUN) && tick_en && (r_count == r_period);
  // Config in force after a wrap/restart: the shadow if one is waiting.
  assign w_eff_period = r_pending ? r_sh_period : r_period;
  assign w_eff_mode   = r_pending ? r_sh_mode   : r_mode;
  assign w_eff_runs   = mode_runs(w_eff_mode) && (w_eff_period != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_count     <= c_ONE;
      r_period    <= '0;
      r_mode      <= MODE_OFF;
      r_sh_period <= '0;
      r_sh_mode   <= MODE_OFF;
      r_pending   <= 1'b0;
      r_strobe    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_count     <= w_count_d;
      r_period    <= w_period_d;
      r_mode      <= w_mode_d;
      r_sh_period <= w_sh_period_d;
      r_sh_mode   <= w_sh_mode_d;
      r_pending   <= w_pending_d;
      r_strobe    <= w_strobe_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_count_d     = r_count;
    w_period_d    = r_period;
    w_mode_d      = r_mode;
    w_sh_period_d = r_sh_period;
    w_sh_mode_d   = r_sh_mode;
    w_pending_d   = r_pending;
    w_strobe_d    = 1'b0;

    if (r_state == ST_IDLE) begin
      // Start sees the config that was active before this cycle's write.
      if (start && mode_runs(r_mode) && (r_period != '0)) begin
        w_state_d = ST_RUN;
        w_count_d = c_ONE;
      end
      // A shadow left over from a one-shot that ended on its write cycle.
      if (r_pending) begin
        w_period_d  = r_sh_period;
        w_mode_d    = r_sh_mode;
        w_pending_d = 1'b0;
      end
      if (cfg_we) begin
        w_period_d = cfg_period;
        w_mode_d   = cfg_mode;
      end
    end else begin
      if (start || w_wrap) begin
        w_count_d = c_ONE;
        if (r_pending) begin
          w_period_d  = r_sh_period;
          w_mode_d    = r_sh_mode;
          w_pending_d = 1'b0;
        end
        if (!w_eff_runs) begin
          w_state_d = ST_IDLE;
        end else if (!start) begin
          w_strobe_d = 1'b1;
          if (r_mode == MODE_ONESHOT) begin
            w_state_d = ST_IDLE;
          end
        end
      end else if (tick_en) begin
        w_count_d = r_count + c_ONE;
      end
      // Writes to a running channel wait for the next wrap or restart.
      if (cfg_we) begin
        w_sh_period_d = cfg_period;
        w_sh_mode_d   = cfg_mode;
        w_pending_d   = 1'b1;
      end
    end
  end

  assign strobe       = r_strobe;
  assign busy         = (r_state == ST_RUN);
  assign pending_next = w_pending_d;

endmodule

`default_nettype wire

// File: rtl/strobe_timer_array.sv
//==============================================================================
// Module : strobe_timer_array -- CHANNELS strobe timers behind one config port
// Rev    : 1.0
//==============================================================================
`default_nettype none

module strobe_timer_array
  import strobe_timer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_en,
  input  logic [CHANNELS-1:0] start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_BITS-1:0]  cfg_chan,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic [1:0]          cfg_mode,
  output logic [CHANNELS-1:0] strobe,
  output logic [CHANNELS-1:0] busy
);

  logic                r_ready;
  logic                w_xfer;
  logic [CHANNELS-1:0] w_pending_next;

  assign w_xfer    = cfg_valid && r_ready;
  assign cfg_ready = r_ready;

  // Ready tracks next-cycle pending so a second write can never slip in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= ~(|w_pending_next);
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic w_we;
    // Out-of-range channel indices match no instance and are dropped.
    assign w_we = w_xfer && (cfg_chan == CH_BITS'(gi));

    strobe_timer_channel #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .tick_en      (tick_en),
      .start        (start[gi]),
      .cfg_we       (w_we),
      .cfg_period   (cfg_period),
      .cfg_mode     (cfg_mode),
      .strobe       (strobe[gi]),
      .busy         (busy[gi]),
      .pending_next (w_pending_next[gi])
    );
  end

endmodule

`default_nettype wire
